// File: rtl/ndma_obi_sub_mem_if.sv
// OBI request/response bundle between a NanoDMA manager port and a subordinate.
// Request attributes are only meaningful in the cycle req is high.
interface ndma_obi_sub_mem_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ndma_obi_sub_mem.sv
// Word-organised OBI subordinate memory with programmable grant and response
// latency. One transaction is held at a time; writes commit on the gnt cycle,
// reads return data in the single rvalid cycle.
module ndma_obi_sub_mem #(
  parameter int unsigned NumWords    = 256,
  parameter int unsigned GntDelay    = 0,
  parameter int unsigned RvalidDelay = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              busy_o,
  ndma_obi_sub_mem_if.slave obi_sub
);

  localparam int unsigned AW       = $clog2(NumWords);
  localparam int unsigned MaxDelay = (GntDelay > RvalidDelay) ? GntDelay : RvalidDelay;
  localparam int unsigned CntW     = (MaxDelay < 1) ? 1 : $clog2(MaxDelay + 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT_WAIT,
    RESP_WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              capture;
  logic              commit;
  logic              gnt;
  logic              rvalid;

  logic [AW-1:0]     idx_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [NumWords];

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{obi_sub.addr[31:AW+2], obi_sub.addr[1:0]};

  // State and latency counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic plus the gnt/rvalid pulses and capture/commit strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    gnt     = 1'b0;
    rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (obi_sub.req) begin
          capture = 1'b1;
          state_d = GNT_WAIT;
          cnt_d   = CntW'(GntDelay);
        end
      end
      GNT_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          gnt    = 1'b1;
          commit = we_q;
          if (RvalidDelay == 1) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = RESP_WAIT;
            cnt_d   = CntW'(RvalidDelay - 1);
          end
        end
      end
      RESP_WAIT: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      RESP: begin
        rvalid = 1'b1;
        if (obi_sub.req) begin
          capture = 1'b1;
          state_d = GNT_WAIT;
          cnt_d   = CntW'(GntDelay);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Latch the request attributes; the bus is not looked at again afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      idx_q   <= obi_sub.addr[AW+1:2];
      we_q    <= obi_sub.we;
      be_q    <= obi_sub.be;
      wdata_q <= obi_sub.wdata;
    end
  end

  // Memory array: cleared on reset, byte-masked write at the end of the gnt cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumWords; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  // Read data is only driven in the rvalid cycle of a read, zero otherwise.
  always_comb begin
    obi_sub.rdata = '0;
    if (rvalid && !we_q) begin
      obi_sub.rdata = mem[idx_q];
    end
  end

  assign obi_sub.gnt    = gnt;
  assign obi_sub.rvalid = rvalid;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_ndma_obi_sub_mem.sv
// Bench for ndma_obi_sub_mem: two instances (default latency and GntDelay=2 /
// RvalidDelay=3 with 16 words) checked every cycle against a transaction-level
// model that predicts gnt/rvalid cycles and read data from request timestamps.
module tb_ndma_obi_sub_mem;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   checking = 1'b0;

  always #5 clk = ~clk;

  // Cycle number; the cycle that starts at a rising edge carries the new number.
  always @(posedge clk) cyc <= cyc + 1;

  // Per-instance drive and observe arrays (index 0 = default, 1 = slow/small).
  logic        req_d   [2];
  logic        we_d    [2];
  logic [31:0] addr_d  [2];
  logic [3:0]  be_d    [2];
  logic [31:0] wdata_d [2];
  logic        gnt_s   [2];
  logic        rv_s    [2];
  logic [31:0] rd_s    [2];
  logic        busy_s  [2];

  ndma_obi_sub_mem_if bus_a ();
  ndma_obi_sub_mem_if bus_b ();

  assign bus_a.req   = req_d[0];
  assign bus_a.we    = we_d[0];
  assign bus_a.addr  = addr_d[0];
  assign bus_a.be    = be_d[0];
  assign bus_a.wdata = wdata_d[0];
  assign bus_b.req   = req_d[1];
  assign bus_b.we    = we_d[1];
  assign bus_b.addr  = addr_d[1];
  assign bus_b.be    = be_d[1];
  assign bus_b.wdata = wdata_d[1];
  assign gnt_s[0] = bus_a.gnt;
  assign rv_s[0]  = bus_a.rvalid;
  assign rd_s[0]  = bus_a.rdata;
  assign gnt_s[1] = bus_b.gnt;
  assign rv_s[1]  = bus_b.rvalid;
  assign rd_s[1]  = bus_b.rdata;

  ndma_obi_sub_mem #(.NumWords(256), .GntDelay(0), .RvalidDelay(1)) dut_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .busy_o  (busy_s[0]),
    .obi_sub (bus_a)
  );

  ndma_obi_sub_mem #(.NumWords(16), .GntDelay(2), .RvalidDelay(3)) dut_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .busy_o  (busy_s[1]),
    .obi_sub (bus_b)
  );

  // Reference model: one outstanding transaction per instance, timestamped.
  int          g_del [2] = '{0, 2};
  int          r_del [2] = '{1, 3};
  int          words [2] = '{256, 16};
  bit          pend  [2];
  int          t_req [2];
  bit          m_we  [2];
  int          m_idx [2];
  bit [3:0]    m_be  [2];
  bit [31:0]   m_wd  [2];
  bit [31:0]   mem_m [2][256];

  // Observed-event log used by the hand-computed checks.
  int          last_gnt [2];
  int          last_rv  [2];
  logic [31:0] last_rd  [2];
  int          gnt_cnt  [2];
  int          rv_cnt   [2];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  // Compare every cycle, log events, then advance the model by one cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit        e_gnt;
      bit        e_rv;
      bit [31:0] e_rd;
      e_gnt = pend[d] && (cyc == t_req[d] + 1 + g_del[d]);
      e_rv  = pend[d] && (cyc == t_req[d] + 1 + g_del[d] + r_del[d]);
      e_rd  = (e_rv && !m_we[d]) ? mem_m[d][m_idx[d]] : 32'h0;
      if (checking) begin
        check_output($sformatf("gnt[%0d]", d), 32'(gnt_s[d]), 32'(e_gnt));
        check_output($sformatf("rvalid[%0d]", d), 32'(rv_s[d]), 32'(e_rv));
        check_output($sformatf("rdata[%0d]", d), rd_s[d], e_rd);
        check_output($sformatf("busy[%0d]", d), 32'(busy_s[d]), 32'(pend[d]));
        if (gnt_s[d] === 1'b1) begin
          last_gnt[d] = cyc;
          gnt_cnt[d]++;
        end
        if (rv_s[d] === 1'b1) begin
          last_rv[d] = cyc;
          last_rd[d] = rd_s[d];
          rv_cnt[d]++;
        end
      end
      if (e_gnt && m_we[d]) begin
        for (int b = 0; b < 4; b++) begin
          if (m_be[d][b]) mem_m[d][m_idx[d]][8*b +: 8] = m_wd[d][8*b +: 8];
        end
      end
      if (e_rv) pend[d] = 1'b0;
      if (rst_n !== 1'b1) begin
        pend[d] = 1'b0;
        for (int i = 0; i < 256; i++) mem_m[d][i] = 32'h0;
      end else if (!pend[d] && req_d[d] === 1'b1) begin
        pend[d]  = 1'b1;
        t_req[d] = cyc;
        m_we[d]  = we_d[d];
        m_idx[d] = int'((addr_d[d] >> 2) % words[d]);
        m_be[d]  = be_d[d];
        m_wd[d]  = wdata_d[d];
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle request on instance d; attributes become garbage afterwards.
  task automatic apply_stimulus(input int d, input bit we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata);
    req_d[d]   = 1'b1;
    we_d[d]    = we;
    addr_d[d]  = addr;
    be_d[d]    = be;
    wdata_d[d] = wdata;
    @(posedge clk);
    #1;
    req_d[d]   = 1'b0;
    we_d[d]    = 1'($urandom);
    addr_d[d]  = $urandom;
    be_d[d]    = 4'($urandom);
    wdata_d[d] = $urandom;
  endtask

  initial begin
    int t;
    int g0;
    int v0;
    for (int d = 0; d < 2; d++) begin
      req_d[d] = 1'b0; we_d[d] = 1'b0; addr_d[d] = '0; be_d[d] = '0; wdata_d[d] = '0;
      pend[d] = 1'b0; gnt_cnt[d] = 0; rv_cnt[d] = 0;
      last_gnt[d] = -1; last_rv[d] = -1; last_rd[d] = '0;
    end
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    checking = 1'b1;
    idle(2);

    $display("[TB] write then read with default latency");
    t = cyc;
    apply_stimulus(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    idle(2);
    check_output("t1 write gnt cycle", 32'(last_gnt[0]), 32'(t + 1));
    check_output("t1 write rvalid cycle", 32'(last_rv[0]), 32'(t + 2));
    check_output("t1 write rdata", last_rd[0], 32'h0);
    t = cyc;
    apply_stimulus(0, 1'b0, 32'h10, 4'hF, 32'h0);
    idle(2);
    check_output("t1 read gnt cycle", 32'(last_gnt[0]), 32'(t + 1));
    check_output("t1 read rvalid cycle", 32'(last_rv[0]), 32'(t + 2));
    check_output("t1 read rdata", last_rd[0], 32'hDEADBEEF);

    $display("[TB] byte-masked write");
    apply_stimulus(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
    idle(2);
    apply_stimulus(0, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD);
    idle(2);
    apply_stimulus(0, 1'b0, 32'h20, 4'hF, 32'h0);
    idle(2);
    check_output("t2 masked read", last_rd[0], 32'h11BB33DD);
    check_output("t2 model word", mem_m[0][8], 32'h11BB33DD);

    $display("[TB] configured latency with ignored request");
    g0 = gnt_cnt[1];
    t = cyc;
    apply_stimulus(1, 1'b0, 32'h8, 4'hF, 32'h0);
    idle(3);
    apply_stimulus(1, 1'b1, 32'h8, 4'hF, 32'h99999999);
    idle(2);
    check_output("t3 gnt cycle", 32'(last_gnt[1]), 32'(t + 3));
    check_output("t3 rvalid cycle", 32'(last_rv[1]), 32'(t + 6));
    check_output("t3 rdata", last_rd[1], 32'h0);
    check_output("t3 single gnt", 32'(gnt_cnt[1] - g0), 32'd1);
    apply_stimulus(1, 1'b0, 32'h8, 4'hF, 32'h0);
    idle(6);
    check_output("t3 ignored write not stored", last_rd[1], 32'h0);

    $display("[TB] back-to-back with aliasing");
    t = cyc;
    apply_stimulus(0, 1'b1, 32'h404, 4'hF, 32'h5);
    idle(1);
    apply_stimulus(0, 1'b0, 32'h4, 4'hF, 32'h0);
    idle(2);
    check_output("t4 read rvalid cycle", 32'(last_rv[0]), 32'(t + 4));
    check_output("t4 aliased rdata", last_rd[0], 32'h5);
    check_output("t4 model word 1", mem_m[0][1], 32'h5);

    $display("[TB] reset mid-transaction");
    g0 = gnt_cnt[1];
    v0 = rv_cnt[1];
    apply_stimulus(1, 1'b1, 32'h30, 4'hF, 32'hFFFFFFFF);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(5);
    check_output("t5 no gnt after abort", 32'(gnt_cnt[1]), 32'(g0));
    check_output("t5 no rvalid after abort", 32'(rv_cnt[1]), 32'(v0));
    apply_stimulus(1, 1'b0, 32'h30, 4'hF, 32'h0);
    idle(7);
    check_output("t5 read after abort", last_rd[1], 32'h0);

    $display("[TB] zero byte-enable write");
    apply_stimulus(0, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
    idle(2);
    g0 = gnt_cnt[0];
    v0 = rv_cnt[0];
    apply_stimulus(0, 1'b1, 32'h40, 4'h0, 32'h12345678);
    idle(2);
    check_output("t6 gnt issued", 32'(gnt_cnt[0] - g0), 32'd1);
    check_output("t6 rvalid issued", 32'(rv_cnt[0] - v0), 32'd1);
    apply_stimulus(0, 1'b0, 32'h40, 4'hF, 32'h0);
    idle(2);
    check_output("t6 read unchanged", last_rd[0], 32'hCAFEF00D);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 2; d++) begin
        req_d[d]   = 1'($urandom_range(0, 1));
        we_d[d]    = 1'($urandom_range(0, 1));
        addr_d[d]  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2)
                     | 32'($urandom_range(0, 3));
        be_d[d]    = 4'($urandom);
        wdata_d[d] = $urandom;
      end
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      idle(1);
    end
    req_d[0] = 1'b0;
    req_d[1] = 1'b0;
    rst_n = 1'b1;
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
